// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefDepth = 16;

  // Pointer width: address bits plus one wrap bit to tell full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: Width x Depth, one synchronous write port, one read port.
// Build option FIFO_FWFT_EN: combinational read (head word always visible);
// otherwise the read port is registered and only updates on a read request.
module fifo_mem #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  // Storage is intentionally not reset; pointers alone define valid contents.
  logic [Width-1:0] mem_q [Depth];

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

`ifdef FIFO_FWFT_EN
  assign rdata_o = mem_q[raddr_i];

  logic unused_ctrl;
  assign unused_ctrl = rst_i ^ re_i;
`else
  logic [Width-1:0] rdata_q, rdata_d;

  // Read register captures the addressed word only on a read; otherwise holds.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) rdata_d = mem_q[raddr_i];
  end

  // Read register state; cleared by reset so rdata reads 0 afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised single-clock FIFO with registered status flags and
// one-cycle overflow/underflow error pulses.
// Build option FIFO_FWFT_EN: first-word-fall-through read side; without it
// rdata/rd_valid update one cycle after an accepted read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DefWidth,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        w_en,
  input  logic [WIDTH-1:0]            wdata,
  input  logic                        r_en,
  output logic [WIDTH-1:0]            rdata,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        w_er,
  output logic                        r_er,
  output logic [ptr_width(DEPTH)-1:0] count
);

  localparam int unsigned PtrW  = ptr_width(DEPTH);
  localparam int unsigned AddrW = PtrW - 1;
  localparam logic [PtrW-1:0] AfLvl = PtrW'(AF_LEVEL);
  localparam logic [PtrW-1:0] AeLvl = PtrW'(AE_LEVEL);

  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             af_q, af_d, ae_q, ae_d;
  logic             w_er_q, w_er_d, r_er_q, r_er_d;
  logic             w_acc, r_acc;
  logic [WIDTH-1:0] mem_rdata;

  // Accept decisions use the registered flags, then derive next pointers and
  // next-cycle status so every flag is a flop output.
  always_comb begin
    w_acc   = w_en && !full_q;
    r_acc   = r_en && !empty_q;
    wptr_d  = wptr_q + {{(PtrW-1){1'b0}}, w_acc};
    rptr_d  = rptr_q + {{(PtrW-1){1'b0}}, r_acc};
    count_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AddrW-1:0] == rptr_d[AddrW-1:0]) && (wptr_d[AddrW] != rptr_d[AddrW]);
    af_d    = (count_d >= AfLvl);
    ae_d    = (count_d <= AeLvl);
    w_er_d  = w_en && full_q;
    r_er_d  = r_en && empty_q;
  end

  // Pointer and status registers; reset discards contents immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      w_er_q  <= 1'b0;
      r_er_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      w_er_q  <= w_er_d;
      r_er_q  <= r_er_d;
    end
  end

  fifo_mem #(
    .Width (WIDTH),
    .Depth (DEPTH)
  ) u_mem (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (w_acc),
    .waddr_i (wptr_q[AddrW-1:0]),
    .wdata_i (wdata),
    .re_i    (r_acc),
    .raddr_i (rptr_q[AddrW-1:0]),
    .rdata_o (mem_rdata)
  );

`ifdef FIFO_FWFT_EN
  // Head word is visible whenever the FIFO holds data; zero when empty.
  assign rd_valid = !empty_q;
  assign rdata    = empty_q ? '0 : mem_rdata;
`else
  logic rd_valid_q, rd_valid_d;

  // rd_valid marks the cycle after an accepted read.
  always_comb begin
    rd_valid_d = r_acc;
  end

  // rd_valid register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_valid_d;
  end

  assign rd_valid = rd_valid_q;
  assign rdata    = mem_rdata;
`endif

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign w_er         = w_er_q;
  assign r_er         = r_er_q;
  assign count        = count_q;

endmodule
